// File: rtl/stack.sv
// stack: synchronous LIFO of DEPTH words of WIDTH bits.
// Data_Out is a registered pop result; Full/Empty decode the occupancy count.
module stack #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             Push,
    input  logic             Pop,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Full,
    output logic             Empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];

    logic          pop_ok;
    logic          push_ok;
    logic          swap_ok;
    logic          wr_en;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;

    // Status decode and operation qualification.
    // Push+Pop on a non-empty stack replaces the top entry in place;
    // on an empty stack it degenerates to a plain push.
    always_comb begin
        Full    = (count == CW'(DEPTH));
        Empty   = (count == '0);
        pop_ok  = Pop && !Empty;
        swap_ok = Push && Pop && !Empty;
        push_ok = Push && (Pop ? Empty : !Full);
        top_idx = AW'(count - CW'(1));
        wr_idx  = swap_ok ? top_idx : AW'(count);
        wr_en   = RstN && (push_ok || swap_ok);
    end

    // Occupancy counter; changes only for a push-only or pop-only operation.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            count <= '0;
        end else if (push_ok) begin
            count <= count + CW'(1);
        end else if (pop_ok && !Push) begin
            count <= count - CW'(1);
        end
    end

    // Registered read of the top entry on every successful pop.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            Data_Out <= '0;
        end else if (pop_ok) begin
            Data_Out <= mem[top_idx];
        end
    end

    // Storage array; contents survive reset and are don't-care above count.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_idx] <= Data_In;
        end
    end

endmodule

// File: tb/tb_stack.sv
// tb_stack: scoreboard bench for the LIFO stack.
module tb_stack;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 8;

    logic             Clk = 1'b0;
    logic             RstN;
    logic [WIDTH-1:0] Data_In;
    logic             Push;
    logic             Pop;
    logic [WIDTH-1:0] Data_Out;
    logic             Full;
    logic             Empty;

    stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk      (Clk),
        .RstN     (RstN),
        .Data_In  (Data_In),
        .Push     (Push),
        .Pop      (Pop),
        .Data_Out (Data_Out),
        .Full     (Full),
        .Empty    (Empty)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [WIDTH-1:0] dout;
        logic             empty;
        logic             full;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] mdl [$];
    logic [WIDTH-1:0] mout;
    exp_t             sb  [$];

    logic [WIDTH-1:0] drain_exp [8] = '{4'd2, 4'd1, 4'd14, 4'd12, 4'd10, 4'd8, 4'd6, 4'd4};
    logic [WIDTH-1:0] fill_val  [8] = '{4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd1, 4'd2};

    // Count one comparison and report a mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of strobes, predict the outcome, compare after the edge.
    task automatic op(input logic push, input logic pop, input logic [WIDTH-1:0] d, input string tag);
        exp_t e;
        @(negedge Clk);
        Push    = push;
        Pop     = pop;
        Data_In = d;
        if (pop && mdl.size() > 0) begin
            mout = mdl.pop_back();
            if (push) mdl.push_back(d);
        end else if (push && mdl.size() < DEPTH) begin
            mdl.push_back(d);
        end
        sb.push_back('{dout: mout, empty: (mdl.size() == 0), full: (mdl.size() == DEPTH)});
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check({tag, "_dout"},  32'(Data_Out), 32'(e.dout));
        check({tag, "_empty"}, 32'(Empty),    32'(e.empty));
        check({tag, "_full"},  32'(Full),     32'(e.full));
    endtask

    initial begin
        RstN    = 1'b0;
        Push    = 1'b1;
        Pop     = 1'b0;
        Data_In = 4'd5;
        mout    = '0;

        // Reset held with a push strobe active.
        repeat (3) @(posedge Clk);
        #1;
        check("rst_empty", 32'(Empty),    32'd1);
        check("rst_full",  32'(Full),     32'd0);
        check("rst_dout",  32'(Data_Out), 32'd0);
        @(negedge Clk);
        Push = 1'b0;
        RstN = 1'b1;
        @(posedge Clk);
        #1;
        check("rel_empty", 32'(Empty), 32'd1);

        // Fill to capacity.
        for (int i = 0; i < 8; i++) op(1'b1, 1'b0, fill_val[i], "fill");
        check("fill_full_const", 32'(Full), 32'd1);

        // Overflow is ignored.
        op(1'b1, 1'b0, 4'd9, "ovf");

        // Drain everything.
        for (int i = 0; i < 8; i++) begin
            op(1'b0, 1'b1, 4'd0, "drain");
            check("drain_const", 32'(Data_Out), 32'(drain_exp[i]));
        end
        check("drain_empty_const", 32'(Empty), 32'd1);

        // Underflow holds Data_Out.
        op(1'b0, 1'b1, 4'd0, "udf");
        check("udf_hold_const", 32'(Data_Out), 32'd4);

        // Asynchronous reset between edges with two entries stored.
        op(1'b1, 1'b0, 4'd5, "pre_rst");
        op(1'b1, 1'b0, 4'd11, "pre_rst");
        @(negedge Clk);
        Push = 1'b0;
        Pop  = 1'b0;
        #1;
        RstN = 1'b0;
        #1;
        check("mid_rst_empty", 32'(Empty),    32'd1);
        check("mid_rst_dout",  32'(Data_Out), 32'd0);
        #1;
        RstN = 1'b1;
        mdl.delete();
        mout = '0;
        op(1'b1, 1'b0, 4'd9, "post_rst");
        op(1'b0, 1'b1, 4'd0, "post_rst");
        check("post_rst_const", 32'(Data_Out), 32'd9);

        // Simultaneous strobes.
        op(1'b1, 1'b0, 4'd3, "sim");
        op(1'b1, 1'b1, 4'd7, "swap");
        check("swap_const", 32'(Data_Out), 32'd3);
        op(1'b0, 1'b1, 4'd0, "swap_pop");
        check("swap_pop_const", 32'(Data_Out), 32'd7);
        op(1'b1, 1'b1, 4'd13, "swap_empty");
        check("swap_empty_const", 32'(Data_Out), 32'd7);
        op(1'b0, 1'b1, 4'd0, "swap_empty_pop");
        check("swap_empty_pop_const", 32'(Data_Out), 32'd13);

        @(negedge Clk);
        Push = 1'b0;
        Pop  = 1'b0;
        repeat (2) @(posedge Clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
